mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001: Parameter BASE_ADDR, default 32'h0010_0000, byte address of the boot word holding the program start address.
REQ-002: Parameter STARVE_LIMIT, default 4, number of consecutive denied fetch cycles before fetch is forced to win.
REQ-003: clock  input  1  sole clock; all state updates on the rising edge.
REQ-004: reset_n  input  1  asynchronous, active-low reset.
REQ-005: if_req  input  1  instruction fetch request.
REQ-006: if_addr  input  32  fetch byte address.
REQ-007: if_ready  output  1  one-cycle pulse; if_rdata is valid.
REQ-008: if_rdata  output  32  registered fetch data.
REQ-009: d_req  input  1  data-port request.
REQ-010: d_we  input  1  data-port write enable, qualified by d_req.
REQ-011: d_addr  input  32  data byte address.
REQ-012: d_wdata  input  32  data write value.
REQ-013: d_ready  output  1  one-cycle pulse; access complete.
REQ-014: d_rdata  output  32  registered load data.
REQ-015: mem_addr  output  32  byte address to the shared memory; memory performs the >>2 word indexing.
REQ-016: mem_we  output  1  memory write strobe.
REQ-017: mem_wdata  output  32  memory write data.
REQ-018: mem_rdata  input  32  combinational memory read data for mem_addr.
REQ-019: start_addr  output  32  program start address captured at boot.
REQ-020: boot_done  output  1  high once start_addr is valid.

Function
REQ-021: State machine states BOOT and RUN; reset enters BOOT.
REQ-022: BOOT: mem_addr = BASE_ADDR, mem_we = 0, no grants; on the first rising edge, start_addr <= mem_rdata, boot_done <= 1, state -> RUN (exactly one stall cycle).
REQ-023: RUN: at most one requester granted per cycle; grant is combinational from current-cycle inputs.
REQ-024: Priority: data wins when both request, unless starve_cnt == STARVE_LIMIT, then fetch wins.
REQ-025: starve_cnt increments (saturating at STARVE_LIMIT) each cycle if_req=1 and fetch not granted; clears to 0 when fetch granted or if_req=0.
REQ-026: Granted cycle N: mem_addr = granted address; mem_we = d_we only when data granted; mem_wdata = d_wdata.
REQ-027: No grant: mem_addr = if_addr, mem_we = 0.
REQ-028: Read granted in cycle N: mem_rdata captured at the end of N into X_rdata; X_ready = 1 during N+1 only.
REQ-029: Write granted in cycle N: memory writes at the end of N; d_ready = 1 during N+1; d_rdata unchanged.
REQ-030: A requester holding req high during its ready cycle issues a new access (back-to-back, one per cycle max); requesters drop or change req/address in the ready cycle to avoid a repeat.
REQ-031: Ungranted requester holds req and address stable; arbiter never loses a pending request.
REQ-032: X_rdata holds its value until the next completed read on that port.
REQ-033: if_ready and d_ready never asserted in the same cycle.

Reset
REQ-034: reset_n low asynchronously forces: state BOOT, if_ready 0, d_ready 0, if_rdata 0, d_rdata 0, start_addr 0, boot_done 0, starve_cnt 0; mem_we 0 while reset_n low.
REQ-035: Reset mid-access discards any pending response; no ready pulse follows for it.
REQ-036: After reset_n rises, boot sequence (REQ-022) repeats before any grant.

Verification
REQ-037: Boot: mem word at 0x0010_0000 = 0x0040_0000, release reset -> cycle 1 mem_addr 0x0010_0000, after first edge start_addr 0x0040_0000, boot_done 1; if_req held high gets first grant in cycle 2.
REQ-038: Fetch alone: if_req=1, if_addr 0x0040_0004 in cycle N -> if_ready 1 and if_rdata = mem[0x0040_0004] in N+1; held req gives a pulse every cycle.
REQ-039: Contention: if_req and d_req (read) both high continuously -> data granted 4 cycles, fetch granted on 5th (STARVE_LIMIT=4), pattern repeats; no simultaneous ready pulses.
REQ-040: Write then read: d_we=1, d_addr 0x1000_0000, d_wdata 0xDEAD_BEEF cycle N -> mem_we 1 in N, d_ready in N+1; read same address cycle N+1 -> d_rdata 0xDEAD_BEEF in N+2.
REQ-041: Mid-access reset: grant read in cycle N, assert reset_n low before edge ending N -> no ready pulse, all outputs at reset values, boot repeats after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter for instruction fetch and data ports.
// Boots by reading the program start address, then arbitrates with data priority and fetch anti-starvation.
module mem_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'h0010_0000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] start_addr,
  output logic        boot_done
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic ST_BOOT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic          r_state;
  logic [CW-1:0] r_starve_cnt;
  logic          r_if_ready;
  logic          r_d_ready;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_d_rdata;
  logic [31:0]   r_start_addr;
  logic          r_boot_done;

  logic w_run;
  logic w_starved;
  logic w_d_gnt;
  logic w_if_gnt;

  assign w_run     = (r_state == ST_RUN);
  assign w_starved = (r_starve_cnt == LIMIT);
  // Data wins contention unless fetch has been denied STARVE_LIMIT cycles in a row.
  assign w_d_gnt   = w_run & d_req & ~(if_req & w_starved);
  assign w_if_gnt  = w_run & if_req & ~w_d_gnt;

  always_comb begin
    mem_addr = if_addr;
    if (!w_run)
      mem_addr = BASE_ADDR;
    else if (w_d_gnt)
      mem_addr = d_addr;
  end

  assign mem_we    = w_d_gnt & d_we;
  assign mem_wdata = d_wdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_BOOT;
      r_starve_cnt <= '0;
      r_if_ready   <= 1'b0;
      r_d_ready    <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_start_addr <= '0;
      r_boot_done  <= 1'b0;
    end else begin
      r_if_ready <= w_if_gnt;
      r_d_ready  <= w_d_gnt;
      if (r_state == ST_BOOT) begin
        r_start_addr <= mem_rdata;
        r_boot_done  <= 1'b1;
        r_state      <= ST_RUN;
      end
      if (w_if_gnt)
        r_if_rdata <= mem_rdata;
      if (w_d_gnt && !d_we)
        r_d_rdata <= mem_rdata;
      if (!w_run || !if_req || w_if_gnt)
        r_starve_cnt <= '0;
      else if (!w_starved)
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign if_ready   = r_if_ready;
  assign d_ready    = r_d_ready;
  assign if_rdata   = r_if_rdata;
  assign d_rdata    = r_d_rdata;
  assign start_addr = r_start_addr;
  assign boot_done  = r_boot_done;

endmodule
